// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: width helpers shared by the line buffer and its pointer counters.
package line_buffer_pkg;
  function automatic int ptr_w(input int len);
    return ($clog2(len) > 1) ? $clog2(len) : 1;
  endfunction
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction
  function automatic int tap_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/line_buffer_win_if.sv
// line_buffer_win_if: pixel write/read/flush handshake and window/status read-out.
interface line_buffer_win_if
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LINE_LEN = 512,
  parameter int TAPS = 6
);
  logic [DATA_W-1:0] i_data;
  logic i_data_valid;
  logic i_rd_data;
  logic i_flush;
  logic [TAPS*DATA_W-1:0] o_data;
  logic o_taps_valid;
  logic [cnt_w(LINE_LEN)-1:0] o_count;
  logic o_full;
  logic o_empty;
  logic o_overflow;
  logic o_underflow;
  logic o_line_done;
  modport master (
    output i_data, i_data_valid, i_rd_data, i_flush,
    input o_data, o_taps_valid, o_count, o_full, o_empty, o_overflow, o_underflow, o_line_done
  );
  modport slave (
    input i_data, i_data_valid, i_rd_data, i_flush,
    output o_data, o_taps_valid, o_count, o_full, o_empty, o_overflow, o_underflow, o_line_done
  );
endinterface

// File: rtl/lb_mod_counter.sv
// lb_mod_counter: modulo-MOD pointer with clear; o_wrap flags an advance from MOD-1 to 0.
module lb_mod_counter
  import line_buffer_pkg::*;
#(
  parameter int MOD = 2,
  localparam int W = ptr_w(MOD)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_val,
  output logic         o_wrap
);
  logic [W-1:0] r_val;
  logic w_last;
  assign w_last = r_val == W'(MOD - 1);
  assign o_wrap = i_en && w_last;
  assign o_val = r_val;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_val <= '0;
    else if (i_en) r_val <= w_last ? '0 : r_val + W'(1);
  end
endmodule

// File: rtl/line_buffer_win.sv
// line_buffer_win: single-line pixel store with a TAPS-wide combinational window at the read pointer.
module line_buffer_win
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LINE_LEN = 512,
  parameter int TAPS = 6
) (
  input logic i_clk,
  input logic i_rst,
  line_buffer_win_if.slave bus
);
  localparam int PTR_W = ptr_w(LINE_LEN);
  localparam int CNT_W = cnt_w(LINE_LEN);
  logic [DATA_W-1:0] r_mem [LINE_LEN];
  logic [CNT_W-1:0] r_count;
  logic r_overflow, r_underflow, r_line_done;
  logic [PTR_W-1:0] w_wr_ptr, w_rd_ptr;
  logic w_wr_req, w_rd_req, w_wr_acc, w_rd_acc, w_rd_wrap, w_unused_wrap;
  // Flush swallows any concurrent request, so it neither moves pointers nor raises errors.
  assign w_wr_req = bus.i_data_valid && !bus.i_flush;
  assign w_rd_req = bus.i_rd_data && !bus.i_flush;
  assign w_rd_acc = w_rd_req && bus.o_taps_valid;
  assign w_wr_acc = w_wr_req && (!bus.o_full || w_rd_acc);
  lb_mod_counter #(.MOD(LINE_LEN)) u_wr_ptr (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(bus.i_flush), .i_en(w_wr_acc),
    .o_val(w_wr_ptr), .o_wrap(w_unused_wrap)
  );
  lb_mod_counter #(.MOD(LINE_LEN)) u_rd_ptr (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(bus.i_flush), .i_en(w_rd_acc),
    .o_val(w_rd_ptr), .o_wrap(w_rd_wrap)
  );
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[w_wr_ptr] <= bus.i_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      r_count <= '0;
      r_line_done <= 1'b0;
    end else begin
      if (w_wr_acc != w_rd_acc) r_count <= w_wr_acc ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
      r_line_done <= w_rd_wrap;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (w_wr_req && !w_wr_acc);
      r_underflow <= r_underflow | (w_rd_req && !w_rd_acc);
    end
  end
  assign bus.o_count = r_count;
  assign bus.o_full = r_count == CNT_W'(LINE_LEN);
  assign bus.o_empty = r_count == '0;
  assign bus.o_taps_valid = r_count >= CNT_W'(TAPS);
  assign bus.o_overflow = r_overflow;
  assign bus.o_underflow = r_underflow;
  assign bus.o_line_done = r_line_done;
  // Sum fits PTR_W+1 bits because k < LINE_LEN; one conditional subtract gives the modulo.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [PTR_W:0] w_sum;
    logic [PTR_W-1:0] w_addr;
    assign w_sum = {1'b0, w_rd_ptr} + (PTR_W + 1)'(k);
    assign w_addr = PTR_W'(w_sum >= (PTR_W + 1)'(LINE_LEN) ? w_sum - (PTR_W + 1)'(LINE_LEN) : w_sum);
    assign bus.o_data[tap_lsb(k, DATA_W) +: DATA_W] = r_mem[w_addr];
  end
endmodule
